// File: rtl/operand_entry_adder_if.sv
// Switch/button inputs and result outputs of the operand entry adder.
// The slave side is the adder; the master side drives the board inputs.
interface operand_entry_adder_if #(
   parameter int WIDTH = 4
);
   logic [WIDTH-1:0] SW;
   logic             enter_n;
   logic             clear_n;
   logic [WIDTH-1:0] sum;
   logic             carryout;
   logic             result_valid;
   logic [1:0]       phase;

   modport master (
      output SW,
      output enter_n,
      output clear_n,
      input  sum,
      input  carryout,
      input  result_valid,
      input  phase
   );

   modport slave (
      input  SW,
      input  enter_n,
      input  clear_n,
      output sum,
      output carryout,
      output result_valid,
      output phase
   );
endinterface

// File: rtl/operand_entry_adder.sv
// Captures two operands on ENTER presses and holds their sum and carry.
// Buttons are synchronised and edge-detected into registered pulses.
module operand_entry_adder #(
   parameter int WIDTH       = 4,
   parameter int SYNC_STAGES = 2
) (
   input  logic                 CLOCK_50,
   input  logic                 rst_n,
   operand_entry_adder_if.slave bus
);

   typedef enum logic [1:0] {
      WAIT_A = 2'b00,
      WAIT_B = 2'b01,
      SHOW   = 2'b10
   } state_t;

   state_t state, state_nx;

   logic [SYNC_STAGES-1:0] enter_sync;
   logic [SYNC_STAGES-1:0] clear_sync;
   logic                   enter_prev;
   logic                   clear_prev;
   logic                   enter_p;
   logic                   clear_p;

   logic [WIDTH-1:0] reg_a, reg_a_nx;
   logic [WIDTH-1:0] sum_q, sum_nx;
   logic             carry_q, carry_nx;
   logic             valid_q, valid_nx;
   logic [WIDTH:0]   add_w;

   // Idle level is 1 so reset release never looks like a press.
   always_ff @(posedge CLOCK_50 or negedge rst_n) begin
      if (!rst_n) begin
         enter_sync <= '1;
         clear_sync <= '1;
         enter_prev <= 1'b1;
         clear_prev <= 1'b1;
         enter_p    <= 1'b0;
         clear_p    <= 1'b0;
      end else begin
         enter_sync <= {enter_sync[SYNC_STAGES-2:0], bus.enter_n};
         clear_sync <= {clear_sync[SYNC_STAGES-2:0], bus.clear_n};
         enter_prev <= enter_sync[SYNC_STAGES-1];
         clear_prev <= clear_sync[SYNC_STAGES-1];
         enter_p    <= enter_prev & ~enter_sync[SYNC_STAGES-1];
         clear_p    <= clear_prev & ~clear_sync[SYNC_STAGES-1];
      end
   end

   assign add_w = {1'b0, reg_a} + {1'b0, bus.SW};

   always_comb begin
      state_nx = state;
      reg_a_nx = reg_a;
      sum_nx   = sum_q;
      carry_nx = carry_q;
      valid_nx = valid_q;
      if (clear_p) begin
         state_nx = WAIT_A;
         reg_a_nx = '0;
         sum_nx   = '0;
         carry_nx = 1'b0;
         valid_nx = 1'b0;
      end else begin
         unique case (state)
            WAIT_A, SHOW: begin
               if (enter_p) begin
                  state_nx = WAIT_B;
                  reg_a_nx = bus.SW;
                  sum_nx   = bus.SW;
                  carry_nx = 1'b0;
                  valid_nx = 1'b0;
               end
            end
            WAIT_B: begin
               if (enter_p) begin
                  state_nx = SHOW;
                  sum_nx   = add_w[WIDTH-1:0];
                  carry_nx = add_w[WIDTH];
                  valid_nx = 1'b1;
               end
            end
            default: begin
               state_nx = WAIT_A;
               reg_a_nx = '0;
               sum_nx   = '0;
               carry_nx = 1'b0;
               valid_nx = 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge CLOCK_50 or negedge rst_n) begin
      if (!rst_n) begin
         state   <= WAIT_A;
         reg_a   <= '0;
         sum_q   <= '0;
         carry_q <= 1'b0;
         valid_q <= 1'b0;
      end else begin
         state   <= state_nx;
         reg_a   <= reg_a_nx;
         sum_q   <= sum_nx;
         carry_q <= carry_nx;
         valid_q <= valid_nx;
      end
   end

   assign bus.sum          = sum_q;
   assign bus.carryout     = carry_q;
   assign bus.result_valid = valid_q;
   assign bus.phase        = state;

endmodule

// File: tb/tb_operand_entry_adder.sv
// Directed bench for operand_entry_adder: entry, carry, chaining,
// clear priority, held buttons and asynchronous reset.
module tb_operand_entry_adder;

   logic clk;
   logic rst_n;
   int   checks;
   int   errors;

   operand_entry_adder_if #(.WIDTH(4)) bus ();

   operand_entry_adder #(
      .WIDTH       (4),
      .SYNC_STAGES (2)
   ) dut (
      .CLOCK_50 (clk),
      .rst_n    (rst_n),
      .bus      (bus)
   );

   initial clk = 1'b0;
   always #10 clk = ~clk;

   task automatic chk(input string tag,
                      input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h exp %0h", tag, got, exp);
      end
   endtask

   task automatic press(input logic [3:0] v, input int hold);
      @(negedge clk);
      bus.SW      = v;
      bus.enter_n = 1'b0;
      repeat (hold) @(negedge clk);
      bus.enter_n = 1'b1;
      repeat (6) @(negedge clk);
   endtask

   task automatic add_pair(input string tag,
                           input logic [3:0] a,
                           input logic [3:0] b,
                           input logic [3:0] s,
                           input logic c);
      press(a, 4);
      chk({tag, "_echo"}, bus.sum, a);
      chk({tag, "_phb"}, bus.phase, 2'b01);
      press(b, 4);
      chk({tag, "_sum"}, bus.sum, s);
      chk({tag, "_cy"}, bus.carryout, c);
      chk({tag, "_vld"}, bus.result_valid, 1'b1);
      chk({tag, "_phs"}, bus.phase, 2'b10);
   endtask

   initial begin
      checks      = 0;
      errors      = 0;
      rst_n       = 1'b0;
      bus.SW      = '0;
      bus.enter_n = 1'b1;
      bus.clear_n = 1'b1;
      repeat (3) @(negedge clk);
      chk("rst_sum", bus.sum, 4'h0);
      chk("rst_phase", bus.phase, 2'b00);
      rst_n = 1'b1;
      repeat (10) @(negedge clk);
      chk("rel_sum", bus.sum, 4'h0);
      chk("rel_cy", bus.carryout, 1'b0);
      chk("rel_vld", bus.result_valid, 1'b0);
      chk("rel_phase", bus.phase, 2'b00);

      // Basic add with exact latency on the second press
      press(4'd3, 4);
      chk("b_phase1", bus.phase, 2'b01);
      chk("b_echo", bus.sum, 4'd3);
      chk("b_vld0", bus.result_valid, 1'b0);
      @(negedge clk);
      bus.SW      = 4'd4;
      bus.enter_n = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("b_early", bus.result_valid, 1'b0);
      chk("b_early_ph", bus.phase, 2'b01);
      @(posedge clk);
      @(negedge clk);
      chk("b_vld", bus.result_valid, 1'b1);
      chk("b_sum", bus.sum, 4'd7);
      chk("b_cy", bus.carryout, 1'b0);
      chk("b_phase2", bus.phase, 2'b10);
      bus.enter_n = 1'b1;
      repeat (6) @(negedge clk);
      bus.SW = 4'd12;
      repeat (4) @(negedge clk);
      chk("b_hold", bus.sum, 4'd7);

      add_pair("c98", 4'd9, 4'd8, 4'd1, 1'b1);
      add_pair("cff", 4'd15, 4'd15, 4'he, 1'b1);
      add_pair("cf1", 4'd15, 4'd1, 4'd0, 1'b1);
      add_pair("c87", 4'd8, 4'd7, 4'hf, 1'b0);

      // Clear back to WAIT_A, then a held ENTER gives one capture
      @(negedge clk);
      bus.clear_n = 1'b0;
      repeat (4) @(negedge clk);
      bus.clear_n = 1'b1;
      repeat (6) @(negedge clk);
      chk("clr_phase", bus.phase, 2'b00);
      chk("clr_sum", bus.sum, 4'd0);
      chk("clr_cy", bus.carryout, 1'b0);
      press(4'd3, 1000);
      chk("hold_phase", bus.phase, 2'b01);
      chk("hold_sum", bus.sum, 4'd3);
      press(4'd4, 4);
      chk("hold_add", bus.sum, 4'd7);
      chk("hold_ph2", bus.phase, 2'b10);

      // Chain from SHOW directly into a new first operand
      press(4'd5, 4);
      chk("chain_ph", bus.phase, 2'b01);
      chk("chain_sum", bus.sum, 4'd5);
      chk("chain_vld", bus.result_valid, 1'b0);
      chk("chain_cy", bus.carryout, 1'b0);

      // Clear and enter together in WAIT_B: clear wins
      @(negedge clk);
      bus.SW      = 4'd9;
      bus.enter_n = 1'b0;
      bus.clear_n = 1'b0;
      repeat (4) @(negedge clk);
      bus.enter_n = 1'b1;
      bus.clear_n = 1'b1;
      repeat (6) @(negedge clk);
      chk("pri_phase", bus.phase, 2'b00);
      chk("pri_sum", bus.sum, 4'd0);
      chk("pri_vld", bus.result_valid, 1'b0);
      add_pair("pri_add", 4'd2, 4'd3, 4'd5, 1'b0);

      // Asynchronous reset between edges while showing 7
      add_pair("ar", 4'd3, 4'd4, 4'd7, 1'b0);
      @(negedge clk);
      #5;
      rst_n = 1'b0;
      #1;
      chk("ar_sum", bus.sum, 4'd0);
      chk("ar_vld", bus.result_valid, 1'b0);
      chk("ar_phase", bus.phase, 2'b00);
      chk("ar_cy", bus.carryout, 1'b0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (4) @(negedge clk);
      chk("ar_rel_ph", bus.phase, 2'b00);
      add_pair("ar_add", 4'd6, 4'd11, 4'd1, 1'b1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/operand_entry_adder.md
Name: operand_entry_adder

Overview:
- Upstream stage of the two-digit sum display: captures two WIDTH-bit operands from the switches on successive ENTER button presses.
- Adds the two operands and holds the result as sum and carryout for the display stage.
- The display stage shows sum on HEX0 and lights HEX1 only when carryout is 1.
- Synchronises and edge-detects the active-low board pushbuttons internally.

Parameters:
- WIDTH, 4, operand and sum width in bits.
- SYNC_STAGES, 2, flip-flop depth of each button synchroniser (minimum 2).

Ports:
- CLOCK_50  input  1  system clock; all logic on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- SW  input  WIDTH  operand value from the slide switches; asynchronous to the clock.
- enter_n  input  1  ENTER pushbutton, active-low, asynchronous.
- clear_n  input  1  CLEAR pushbutton, active-low, asynchronous.
- sum  output  WIDTH  registered value for the ones digit.
- carryout  output  1  registered carry, bit WIDTH of the addition.
- result_valid  output  1  1 while sum/carryout hold a completed addition.
- phase  output  2  state code for status LEDs: 00 WAIT_A, 01 WAIT_B, 10 SHOW.

Behaviour:
- Reset (rst_n low, any time, asynchronous):
  - state=WAIT_A; reg_a=0; sum=0; carryout=0; result_valid=0; phase=00.
  - Synchroniser and edge flops reset to 1 (button released), so no pulse on reset release.
- Button path:
  - enter_n and clear_n each pass through SYNC_STAGES flops.
  - Falling-edge detect on the synchronised level gives a one-cycle pulse (enter_p, clear_p).
  - A held button produces exactly one pulse; release produces none.
  - Pulse asserts SYNC_STAGES+1 clock edges after the pin falls; outputs update on the following edge.
- SW is sampled only in the cycle an enter_p is active. No SW synchroniser: switches are quasi-static.
- State machine (registered outputs; phase mirrors state):
  - WAIT_A:
    - enter_p -> reg_a<=SW; sum<=SW; carryout<=0; result_valid<=0; go WAIT_B.
    - Otherwise hold; sum=0.
  - WAIT_B:
    - sum echoes reg_a so the display shows the first operand.
    - enter_p -> {carryout,sum}<=reg_a+SW, computed at WIDTH+1 bits with no truncation of the carry; result_valid<=1; go SHOW.
  - SHOW: hold the result indefinitely.
    - enter_p starts the next pair: reg_a<=SW; sum<=SW; carryout<=0; result_valid<=0; go WAIT_B. No extra press is needed.
  - Any state, clear_p: reg_a<=0; sum<=0; carryout<=0; result_valid<=0; go WAIT_A.
  - clear_p and enter_p in the same cycle: clear wins; the enter press is discarded.
  - Illegal state code (11) -> WAIT_A on next edge, outputs cleared.
- Arithmetic:
  - Unsigned. Maximum 15+15=30 gives sum=4'hE, carryout=1.
  - carryout=1 exactly when the true sum >= 2^WIDTH.
- Reset asserted mid-entry (WAIT_B) or in SHOW discards reg_a and the result; after release the block sits in WAIT_A.
- No combinational path from any input to any output.

Test Plan:
- Reset: rst_n low with buttons released, then release -> sum=0, carryout=0, result_valid=0, phase=00; no pulse on release.
- Basic add: SW=3, press ENTER; SW=4, press ENTER -> phase 00->01->10; sum echoes 3 in WAIT_B; final sum=7, carryout=0, result_valid=1, updating SYNC_STAGES+2 edges after the second press.
- Carry: SW=9 then SW=8 -> sum=1, carryout=1. SW=15 then SW=15 -> sum=14, carryout=1. SW=15 then SW=1 -> sum=0, carryout=1.
- Held button and chaining: hold ENTER 1000 cycles in WAIT_A -> exactly one capture, phase=01. In SHOW, SW=5 and press -> phase=01, sum=5, result_valid=0.
- Clear priority: in WAIT_B, assert enter_n and clear_n on the same clock edge -> phase=00, sum=0, reg_a=0, no addition performed.
- Async reset mid-operation: drop rst_n between clock edges in SHOW (sum=7) -> outputs 0 immediately, before the next clock edge; after release the next two presses add correctly.
